iterative_multiplier: RTL and testbench

ITERATIVE_MULTIPLIER -- requirements
Module: iterative_multiplier

---
 rtl/iterative_multiplier.sv | 114 +++++++++++
 tb/tb_iterative_multiplier.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iterative_multiplier.sv
// Iterative radix-2 shift-add multiplier, signed or unsigned operands, one step per clock.
// Accepts one operand pair at a time via valid/ready and holds the product until taken.
module iterative_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 neg_q, neg_d;

  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   acc_step;
  logic [WIDTH-1:0]     mplier_step;

  // Negative two's-complement operands become their unsigned magnitude; -2^(W-1) maps to 2^(W-1).
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  // One shift-add step: add into the upper half, then shift {carry, acc, multiplier} right.
  always_comb begin
    sum         = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    acc_step    = {sum, acc_q[WIDTH-1:1]};
    mplier_step = {acc_q[0], mplier_q[WIDTH-1:1]};
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    product_d = product_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d  = magnitude(a, is_signed);
          mplier_d = magnitude(b, is_signed);
          neg_d    = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          cnt_d    = CW'(WIDTH);
          acc_d    = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        acc_d    = acc_step;
        mplier_d = mplier_step;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          product_d = neg_q ? -acc_step : acc_step;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      product_q <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign product   = product_q;

endmodule

// File: tb/tb_iterative_multiplier.sv
// Bench for iterative_multiplier: directed 32-bit cases with literal results, plus a randomized
// 8-bit instance with backpressure checked every cycle against an arithmetic reference.
module tb_iterative_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst32, in_valid32, in_ready32, is_signed32, out_valid32, out_ready32, busy32;
  logic [31:0] a32, b32;
  logic [63:0] product32;

  logic        rst8, in_valid8, in_ready8, is_signed8, out_valid8, out_ready8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] product8;

  iterative_multiplier #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst32), .in_valid(in_valid32), .in_ready(in_ready32),
    .a(a32), .b(b32), .is_signed(is_signed32), .out_valid(out_valid32),
    .out_ready(out_ready32), .product(product32), .busy(busy32)
  );

  iterative_multiplier #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst8), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .is_signed(is_signed8), .out_valid(out_valid8),
    .out_ready(out_ready8), .product(product8), .busy(busy8)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Exact product of w-bit operands, interpreted as signed or unsigned, truncated to 2*w bits.
  function automatic logic [127:0] ref_mul(input int w, input logic [63:0] x, input logic [63:0] y,
                                           input logic s);
    logic signed [129:0] ex, ey, p;
    logic [127:0] mask;
    ex = $signed({66'd0, x});
    ey = $signed({66'd0, y});
    if (s && x[w-1]) ex = ex - (130'sd1 <<< w);
    if (s && y[w-1]) ey = ey - (130'sd1 <<< w);
    p    = ex * ey;
    mask = (128'd1 << (2 * w)) - 128'd1;
    return p[127:0] & mask;
  endfunction

  // ---------------- 8-bit scoreboard / compare process ----------------
  typedef struct {
    logic [15:0] exp;
    int          acc_edge;
  } item_t;

  item_t q[$];
  int    edge_cnt = 0;
  bit    mon_en = 1'b0;
  bit    seen = 1'b0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  always @(negedge clk) begin
    logic [127:0] full;
    item_t        it;
    if (rst8 || !mon_en) begin
      q.delete();
      seen = 1'b0;
    end else begin
      if (in_valid8 && in_ready8) begin
        full        = ref_mul(8, {56'd0, a8}, {56'd0, b8}, is_signed8);
        it.exp      = full[15:0];
        it.acc_edge = edge_cnt + 1;
        q.push_back(it);
      end
      if (out_valid8) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out8: out_valid with no accepted operands, product %0h", product8);
        end else begin
          if (!seen) check("latency8", 128'(edge_cnt - q[0].acc_edge), 128'd8);
          seen = 1'b1;
          check("product8", 128'(product8), 128'(q[0].exp));
          if (out_ready8) begin
            void'(q.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  function automatic logic [7:0] pick8();
    logic [7:0] corners [5];
    corners = '{8'h00, 8'h01, 8'h7f, 8'h80, 8'hff};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return 8'($urandom);
  endfunction

  // ---------------- 32-bit directed helpers ----------------
  task automatic start32(input logic [31:0] x, input logic [31:0] y, input logic s);
    in_valid32  = 1'b1;
    a32         = x;
    b32         = y;
    is_signed32 = s;
    check("in_ready_before_accept32", 128'(in_ready32), 128'd1);
    @(posedge clk); #1;
    in_valid32  = 1'b0;
    a32         = $urandom;
    b32         = $urandom;
    is_signed32 = ~s;
    check("busy_after_accept32", 128'(busy32), 128'd1);
  endtask

  task automatic wait_done32(input logic [31:0] x, input logic [31:0] y, input logic s,
                             input logic [63:0] exp, input string name);
    int n = 1;
    while (!out_valid32 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_latency"}, 128'(n), 128'd33);
    check({name, "_product"}, 128'(product32), 128'(exp));
    check({name, "_model"}, 128'(product32), ref_mul(32, {32'd0, x}, {32'd0, y}, s));
  endtask

  task automatic consume32(input logic [63:0] exp, input string name);
    out_ready32 = 1'b1;
    @(posedge clk); #1;
    out_ready32 = 1'b0;
    check({name, "_idle_valid"}, 128'(out_valid32), 128'd0);
    check({name, "_idle_ready"}, 128'(in_ready32), 128'd1);
    check({name, "_retained"}, 128'(product32), 128'(exp));
  endtask

  task automatic op32(input logic [31:0] x, input logic [31:0] y, input logic s,
                      input logic [63:0] exp, input string name);
    start32(x, y, s);
    wait_done32(x, y, s, exp, name);
    consume32(exp, name);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    bit saw_valid;
    int k;

    rst32 = 1'b1; in_valid32 = 1'b0; out_ready32 = 1'b0; is_signed32 = 1'b0; a32 = '0; b32 = '0;
    rst8  = 1'b1; in_valid8  = 1'b0; out_ready8  = 1'b0; is_signed8  = 1'b0; a8  = '0; b8  = '0;

    repeat (2) @(posedge clk);
    #1;
    rst32 = 1'b0;
    check("rst_product32", 128'(product32), 128'd0);
    check("rst_out_valid32", 128'(out_valid32), 128'd0);
    check("rst_in_ready32", 128'(in_ready32), 128'd1);
    check("rst_busy32", 128'(busy32), 128'd0);

    op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, "uns_max");
    op32(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, "sgn_min_sq");
    op32(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, "sgn_neg1");
    op32(32'h0000_0000, 32'h8000_0000, 1'b1, 64'h0000_0000_0000_0000, "sgn_zero");
    op32(32'h8000_0000, 32'h0000_0002, 1'b0, 64'h0000_0001_0000_0000, "uns_msb_x2");
    op32(32'h8000_0000, 32'h0000_0002, 1'b1, 64'hFFFF_FFFF_0000_0000, "sgn_msb_x2");

    // Backpressure in DONE while new operands are offered.
    start32(32'd7, 32'd9, 1'b0);
    wait_done32(32'd7, 32'd9, 1'b0, 64'd63, "hold_first");
    in_valid32 = 1'b1; a32 = 32'd3; b32 = 32'd5; is_signed32 = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      check("hold_product", 128'(product32), 128'd63);
      check("hold_in_ready", 128'(in_ready32), 128'd0);
      check("hold_out_valid", 128'(out_valid32), 128'd1);
    end
    out_ready32 = 1'b1;
    @(posedge clk); #1;
    out_ready32 = 1'b0;
    check("handshake_in_ready", 128'(in_ready32), 128'd1);
    check("handshake_busy", 128'(busy32), 128'd0);
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    check("accept_after_handshake", 128'(busy32), 128'd1);
    wait_done32(32'd3, 32'd5, 1'b0, 64'd15, "after_hold");
    consume32(64'd15, "after_hold");

    // Reset in the middle of a calculation.
    start32(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    repeat (10) begin
      @(posedge clk); #1;
    end
    rst32 = 1'b1;
    @(posedge clk); #1;
    rst32 = 1'b0;
    check("midrst_out_valid", 128'(out_valid32), 128'd0);
    check("midrst_in_ready", 128'(in_ready32), 128'd1);
    check("midrst_busy", 128'(busy32), 128'd0);
    check("midrst_product", 128'(product32), 128'd0);
    saw_valid = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid32) saw_valid = 1'b1;
    end
    check("midrst_no_output", 128'(saw_valid), 128'd0);
    op32(32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA, "post_rst");

    // Randomized 8-bit run with backpressure.
    @(posedge clk); #1;
    rst8 = 1'b0;
    mon_en = 1'b1;
    check("rst_product8", 128'(product8), 128'd0);
    check("rst_in_ready8", 128'(in_ready8), 128'd1);
    for (int v = 0; v < 1000; v++) begin
      repeat ($urandom_range(0, 1)) begin
        @(posedge clk); #1;
        out_ready8 = ($urandom_range(0, 3) != 0);
      end
      a8 = pick8();
      b8 = pick8();
      is_signed8 = 1'($urandom_range(0, 1));
      in_valid8 = 1'b1;
      got = 1'b0;
      k = 0;
      while (!got && k < 100) begin
        @(negedge clk);
        got = in_ready8;
        @(posedge clk); #1;
        out_ready8 = ($urandom_range(0, 3) != 0);
        k++;
      end
      in_valid8 = 1'b0;
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      if (!got) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout8: vector %0d not accepted within 100 cycles", v);
        break;
      end
    end
    k = 0;
    while (q.size() != 0 && k < 200) begin
      @(posedge clk); #1;
      out_ready8 = ($urandom_range(0, 1) != 0);
      k++;
    end
    check("drain8", 128'(q.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
